radix4_otf_converter: RTL and testbench

Sequential on-the-fly converter from radix-4 signed quotient digits to a binary mantissa, one digit per cycle as the SRT divider produces them. Maintains the Q / QM register pair, so no final carry-propagate subtraction is needed. Applies the negative-final-remainder correction (Q-1) by selecting QM. Sits between the SRT digit-selection stage and mantissa normalisation/packing; width, digit count and output slice are parametrised.

---
 rtl/radix4_otf_converter.sv | 138 +++++++++++++
 tb/tb_radix4_otf_converter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/radix4_otf_converter.sv
// On-the-fly conversion of radix-4 signed SRT quotient digits into a binary quotient.
// Keeps Q and QM = Q-1 so the negative-remainder correction is a register select, not a subtract.
module radix4_otf_converter #(
    parameter int NDIGITS = 13,
    parameter int OUT_W   = 23,
    localparam int QW     = 2 * NDIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_digit,
    input  logic             rem_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] mantissa,
    output logic [QW-1:0]    q_full,
    output logic             digit_err
);

    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // in_ready is high only in ACCUM, out_valid only in DONE; neither depends on the peer's valid/ready.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   q_q, q_d;
    logic [QW-1:0]   qm_q, qm_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [QW-1:0]   q_full_q, q_full_d;
    logic            derr_q, derr_d;

    logic [1:0]      lo_q, lo_qm;
    logic            q_from_qm, qm_from_qm, illegal;
    logic [QW-1:0]   q_src, qm_src, q_next, qm_next;
    logic            last_digit;

    // Negative digits borrow from QM; illegal codes fall through as digit 0.
    always_comb begin
        lo_q       = 2'd0;
        lo_qm      = 2'd3;
        q_from_qm  = 1'b0;
        qm_from_qm = 1'b1;
        illegal    = 1'b0;
        case (in_digit)
            3'b000: ;
            3'b001: begin lo_q = 2'd1; lo_qm = 2'd0; qm_from_qm = 1'b0; end
            3'b010: begin lo_q = 2'd2; lo_qm = 2'd1; qm_from_qm = 1'b0; end
            3'b110: begin lo_q = 2'd3; lo_qm = 2'd2; q_from_qm = 1'b1; end
            3'b101: begin lo_q = 2'd2; lo_qm = 2'd1; q_from_qm = 1'b1; end
            default: illegal = 1'b1;
        endcase
        q_src   = q_from_qm  ? qm_q : q_q;
        qm_src  = qm_from_qm ? qm_q : q_q;
        q_next  = {q_src[QW-3:0], lo_q};
        qm_next = {qm_src[QW-3:0], lo_qm};
    end

    assign last_digit = (cnt_q == CW'(NDIGITS - 1));

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        qm_d      = qm_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        q_full_d  = q_full_q;
        derr_d    = derr_q;
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        if (clear) begin
            state_d = ACCUM;
            q_d     = '0;
            qm_d    = '1;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        q_d   = q_next;
                        qm_d  = qm_next;
                        err_d = err_q | illegal;
                        if (last_digit) begin
                            state_d  = DONE;
                            q_full_d = rem_neg ? qm_next : q_next;
                            derr_d   = err_q | illegal;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        q_d     = '0;
                        qm_d    = '1;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            q_q      <= '0;
            qm_q     <= '1;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            q_full_q <= '0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            qm_q     <= qm_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            q_full_q <= q_full_d;
            derr_q   <= derr_d;
        end
    end

    assign q_full    = q_full_q;
    assign mantissa  = q_full_q[QW-1 -: OUT_W];
    assign digit_err = derr_q;

endmodule

// File: tb/tb_radix4_otf_converter.sv
// Directed bench for radix4_otf_converter: inputs change on the falling edge,
// outputs are checked on the falling edge against hand-computed constants.
module tb_radix4_otf_converter;

    localparam int NDIGITS = 13;
    localparam int OUT_W   = 23;
    localparam int QW      = 2 * NDIGITS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_digit = 3'b000;
    logic             rem_neg = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] mantissa;
    logic [QW-1:0]    q_full;
    logic             digit_err;

    int n_cmp = 0;
    int n_err = 0;

    radix4_otf_converter #(.NDIGITS(NDIGITS), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .rem_neg   (rem_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mantissa  (mantissa),
        .q_full    (q_full),
        .digit_err (digit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Feeds n digits; digit 0 = d0, digit 1 = d1, digit bad_idx = bad_code, others = fill.
    task automatic feed(input int n, input logic [2:0] d0, input logic [2:0] d1,
                        input logic [2:0] fill, input int bad_idx, input logic [2:0] bad_code,
                        input logic rn);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            if (i == bad_idx)  in_digit = bad_code;
            else if (i == 0)   in_digit = d0;
            else if (i == 1)   in_digit = d1;
            else               in_digit = fill;
            rem_neg = (i == n - 1) ? rn : 1'b0;
            check("in_ready_during_feed", 32'(in_ready), 32'd1);
            check("out_valid_during_feed", 32'(out_valid), 32'd0);
            step();
        end
        in_valid = 1'b0;
        rem_neg  = 1'b0;
        in_digit = 3'b000;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] exp_q,
                                 input logic [31:0] exp_m, input logic exp_err);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_q_full"}, 32'(q_full), exp_q);
        check({tag, "_mantissa"}, 32'(mantissa), exp_m);
        check({tag, "_digit_err"}, 32'(digit_err), 32'(exp_err));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("after_consume_out_valid", 32'(out_valid), 32'd0);
        check("after_consume_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_q_full", 32'(q_full), 32'd0);
        check("reset_mantissa", 32'(mantissa), 32'd0);
        check("reset_digit_err", 32'(digit_err), 32'd0);
        rst_n = 1'b1;

        feed(13, 3'b001, 3'b001, 3'b001, -1, 3'b000, 1'b0);
        expect_result("all_ones", 32'h1555555, 32'h2AAAAA, 1'b0);
        consume();

        feed(13, 3'b010, 3'b000, 3'b000, -1, 3'b000, 1'b0);
        expect_result("two_then_zeros", 32'h2000000, 32'h400000, 1'b0);
        consume();

        feed(13, 3'b001, 3'b110, 3'b000, -1, 3'b000, 1'b0);
        expect_result("one_minus_one", 32'h0C00000, 32'h180000, 1'b0);
        consume();

        feed(13, 3'b001, 3'b001, 3'b001, -1, 3'b000, 1'b1);
        expect_result("ones_rem_neg", 32'h1555554, 32'h2AAAAA, 1'b0);
        consume();

        feed(13, 3'b000, 3'b000, 3'b000, -1, 3'b000, 1'b1);
        expect_result("zeros_rem_neg", 32'h3FFFFFF, 32'h7FFFFF, 1'b0);
        consume();

        feed(13, 3'b101, 3'b000, 3'b000, -1, 3'b000, 1'b0);
        expect_result("minus_two_wrap", 32'h2000000, 32'h400000, 1'b0);
        consume();

        feed(13, 3'b001, 3'b001, 3'b001, 4, 3'b011, 1'b0);
        expect_result("illegal_digit", 32'h1545555, 32'h2A8AAA, 1'b1);
        consume();

        feed(13, 3'b001, 3'b001, 3'b001, -1, 3'b000, 1'b0);
        expect_result("after_illegal", 32'h1555555, 32'h2AAAAA, 1'b0);

        // Backpressure with a producer already holding a digit.
        in_valid  = 1'b1;
        in_digit  = 3'b001;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_q_full", 32'(q_full), 32'h1555555);
        end
        consume();
        feed(13, 3'b010, 3'b000, 3'b000, -1, 3'b000, 1'b0);
        expect_result("after_bp", 32'h2000000, 32'h400000, 1'b0);
        consume();

        // Mid-conversion reset.
        feed(5, 3'b010, 3'b010, 3'b010, -1, 3'b000, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_q_full", 32'(q_full), 32'd0);

        // Mid-conversion clear, with a concurrent digit that must be lost.
        feed(7, 3'b010, 3'b010, 3'b010, -1, 3'b000, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_digit = 3'b001;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_out_valid", 32'(out_valid), 32'd0);
        check("clear_in_ready", 32'(in_ready), 32'd1);
        check("clear_q_full_held", 32'(q_full), 32'd0);
        feed(13, 3'b001, 3'b001, 3'b001, -1, 3'b000, 1'b0);
        expect_result("after_clear", 32'h1555555, 32'h2AAAAA, 1'b0);

        // Clear in DONE drops the unconsumed result but holds the data outputs.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_done_out_valid", 32'(out_valid), 32'd0);
        check("clear_done_in_ready", 32'(in_ready), 32'd1);
        check("clear_done_q_full", 32'(q_full), 32'h1555555);
        check("clear_done_mantissa", 32'(mantissa), 32'h2AAAAA);

        feed(13, 3'b001, 3'b110, 3'b000, -1, 3'b000, 1'b1);
        expect_result("final_qm_path", 32'h0BFFFFF, 32'h17FFFF, 1'b0);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
